arb_rr_4: RTL and testbench

ARB_RR_4 -- requirements
Module: arb_rr_4

---
 rtl/arb_rr_4.sv | 122 ++++++++++++
 tb/tb_arb_rr_4.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/arb_rr_4.sv
// Four-way round-robin arbiter with a per-owner hold limit.
// Ports: clk, rst (sync, active-high), en, req[3:0] -> gnt[3:0] one-hot, gnt_idx[1:0], gnt_valid.
// Latency: one cycle from sampled req to visible grant; back-to-back handover has no idle bubble.
module arb_rr_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;

    logic [3:0] owner_mask;
    logic [3:0] others;
    logic       other_pend;
    logic       keep;
    logic [1:0] ptr_next;
    logic [2:0] idle_pick;
    logic [2:0] rel_pick;

    // Returns {found, index} of the first set bit of r searching p, p+1, p+2, p+3.
    // The loop runs lowest priority first so the highest-priority hit wins.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            c = p + 2'(i);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign owner_mask = 4'b0001 << idx_q;
    assign others     = req & ~owner_mask;
    assign other_pend = |others;
    assign keep       = en && req[idx_q] && ((hold_q < HOLD_LIM) || !other_pend);
    assign ptr_next   = idx_q + 2'd1;
    assign idle_pick  = pick(req, ptr_q);
    // On handover the releasing owner is excluded and the search starts just past it.
    assign rel_pick   = pick(others, ptr_next);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                idx_d  = 2'b00;
                hold_d = 8'd0;
                if (en && idle_pick[2]) begin
                    state_d = GRANT;
                    idx_d   = idle_pick[1:0];
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (keep) begin
                    // Reaching the limit with nobody waiting restarts the hold window.
                    hold_d = (hold_q >= HOLD_LIM) ? 8'd1 : hold_q + 8'd1;
                end else begin
                    // Owner drop, hold expiry and enable drop all fold into one release.
                    ptr_d = ptr_next;
                    if (en && rel_pick[2]) begin
                        idx_d  = rel_pick[1:0];
                        hold_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'b00;
                        hold_d  = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'b00;
                hold_d  = 8'd0;
            end
        endcase
        gnt_d = (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            idx_q   <= 2'b00;
            hold_q  <= 8'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_arb_rr_4.sv
module tb_arb_rr_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_vec;
    int n_err;

    arb_rr_4 #(.MAX_HOLD(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected index and valid are derived from the expected one-hot grant.
    task automatic expect_gnt(input string tag, input logic [3:0] eg);
        logic [1:0] ei;
        case (eg)
            4'b0010: ei = 2'd1;
            4'b0100: ei = 2'd2;
            4'b1000: ei = 2'd3;
            default: ei = 2'd0;
        endcase
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
        chk({tag, ".vld"}, 32'(gnt_valid), 32'(eg != 4'b0000));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Structural invariants sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv.onehot", 32'($onehot0(gnt)), 32'd1);
            chk("inv.valid", 32'(gnt_valid), 32'(gnt != 4'b0000));
            if (gnt_valid) begin
                chk("inv.decode", 32'(gnt), 32'(4'b0001 << gnt_idx));
            end
        end
    end

    logic [3:0] rr_req [5];
    logic [3:0] rr_exp [5];
    logic [3:0] hl_exp [10];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;

        // Reset state
        do_reset();
        expect_gnt("reset", 4'b0000);

        // Basic priority from ptr=0
        en = 1'b1; req = 4'b1010;
        tick();
        expect_gnt("prio", 4'b0010);
        req = 4'b0000;
        tick();
        expect_gnt("drop_to_idle", 4'b0000);

        // Enable low in IDLE issues nothing
        en = 1'b0; req = 4'b1111;
        tick();
        expect_gnt("en_low_idle", 4'b0000);

        // Round-robin with owners dropping for one cycle after each grant
        do_reset();
        rr_req = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req = rr_req[k];
            tick();
            expect_gnt($sformatf("rr%0d", k), rr_exp[k]);
        end

        // Hold limit of 3 between two requesters
        do_reset();
        hl_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                   4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        en = 1'b1; req = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_gnt($sformatf("hold%0d", k), hl_exp[k]);
        end
        // Lone requester keeps its grant past the limit
        req = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_gnt($sformatf("lone%0d", k), 4'b0001);
        end
        // Release with no other candidate goes idle
        req = 4'b0000;
        tick();
        expect_gnt("no_cand", 4'b0000);

        // Drop and expiry together: a single pointer step lands on requester 1
        do_reset();
        en = 1'b1; req = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_gnt($sformatf("both%0d", k), 4'b0001);
        end
        req = 4'b0110;
        tick();
        expect_gnt("both_rel", 4'b0010);

        // Enable drop mid-grant, then wrap from ptr=3 to requester 0
        do_reset();
        en = 1'b1; req = 4'b0100;
        tick();
        expect_gnt("en_grant2", 4'b0100);
        en = 1'b0;
        tick();
        expect_gnt("en_drop", 4'b0000);
        en = 1'b1; req = 4'b0101;
        tick();
        expect_gnt("en_wrap", 4'b0001);

        // Reset mid-grant takes priority over pending requests
        do_reset();
        en = 1'b1; req = 4'b1000;
        tick();
        expect_gnt("rst_own3", 4'b1000);
        tick();
        expect_gnt("rst_hold3", 4'b1000);
        rst = 1'b1; req = 4'b1111;
        tick();
        expect_gnt("rst_mid", 4'b0000);
        rst = 1'b0;
        tick();
        expect_gnt("rst_after", 4'b0001);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
